// File: rtl/stage_fetch0_if.sv
// Fetch0 request, execute resolution and CSR redirect signals.
// Master is the fetch0 side; slave is the consumer/driver side.
interface stage_fetch0_if;
   logic        fe0_valid;
   logic        fe1_stall;
   logic        fe0_specid;
   logic [29:0] fe0_read_addr;
   logic        fe0_ic_read_req;
   logic        ex_valid;
   logic        ex_specid;
   logic        ex_br_taken;
   logic        ex_br_ntaken;
   logic [29:0] ex_br_target;
   logic        ex_btb_update;
   logic [29:0] ex_btb_pc;
   logic [29:0] ex_btb_target;
   logic        ex_btb_taken;
   logic        csr_kill;
   logic [29:0] csr_redirect_pc;

   modport master (
      output fe0_valid,
      output fe0_specid,
      output fe0_read_addr,
      output fe0_ic_read_req,
      input  fe1_stall,
      input  ex_valid,
      input  ex_specid,
      input  ex_br_taken,
      input  ex_br_ntaken,
      input  ex_br_target,
      input  ex_btb_update,
      input  ex_btb_pc,
      input  ex_btb_target,
      input  ex_btb_taken,
      input  csr_kill,
      input  csr_redirect_pc
   );

   modport slave (
      input  fe0_valid,
      input  fe0_specid,
      input  fe0_read_addr,
      input  fe0_ic_read_req,
      output fe1_stall,
      output ex_valid,
      output ex_specid,
      output ex_br_taken,
      output ex_br_ntaken,
      output ex_br_target,
      output ex_btb_update,
      output ex_btb_pc,
      output ex_btb_target,
      output ex_btb_taken,
      output csr_kill,
      output csr_redirect_pc
   );
endinterface

// File: rtl/stage_fetch0.sv
// First fetch stage: owns the fetch PC, the speculation ID
// and a direct-mapped BTB used for next-PC prediction.
module stage_fetch0 #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 16
) (
   input  logic           clk_core,
   input  logic           reset,
   stage_fetch0_if.master fe
);

   localparam int IDXW = $clog2(BTB_ENTRIES);
   localparam int TAGW = 30 - IDXW;
   localparam logic [29:0] RST_WA = RESET_PC[31:2];

   logic            valid_q;
   logic            specid_q;
   logic [29:0]     pc_q;
   logic            specid_d;
   logic [29:0]     pc_d;

   logic            mispredict;
   logic            btb_hit;
   logic [IDXW-1:0] lk_idx;
   logic [TAGW-1:0] lk_tag;
   logic [IDXW-1:0] wr_idx;
   logic [TAGW-1:0] wr_tag;

   logic [BTB_ENTRIES-1:0] btb_vld;
   logic [TAGW-1:0]        btb_tag [BTB_ENTRIES];
   logic [29:0]            btb_tgt [BTB_ENTRIES];

   assign lk_idx = pc_q[IDXW-1:0];
   assign lk_tag = pc_q[29:IDXW];
   assign wr_idx = fe.ex_btb_pc[IDXW-1:0];
   assign wr_tag = fe.ex_btb_pc[29:IDXW];

   // Same kill equation fetch1 applies to in-flight requests
   assign mispredict = fe.ex_valid &
      ((specid_q ^ fe.ex_specid) ? fe.ex_br_ntaken
                                 : fe.ex_br_taken);

   assign btb_hit = btb_vld[lk_idx] &
      (btb_tag[lk_idx] == lk_tag);

   always_comb begin
      pc_d     = pc_q;
      specid_d = specid_q;
      if (fe.csr_kill) begin
         pc_d = fe.csr_redirect_pc;
      end else if (mispredict) begin
         pc_d     = fe.ex_br_target;
         specid_d = fe.ex_br_taken ? ~fe.ex_specid
                                   : fe.ex_specid;
      end else if (fe.fe1_stall || !valid_q) begin
         pc_d = pc_q;
      end else if (btb_hit) begin
         pc_d     = btb_tgt[lk_idx];
         specid_d = ~specid_q;
      end else begin
         pc_d = pc_q + 30'd1;
      end
   end

   always_ff @(posedge clk_core) begin
      if (reset) begin
         valid_q  <= 1'b0;
         specid_q <= 1'b0;
         pc_q     <= RST_WA;
      end else begin
         valid_q  <= 1'b1;
         specid_q <= specid_d;
         pc_q     <= pc_d;
      end
   end

   always_ff @(posedge clk_core) begin
      if (reset) begin
         btb_vld <= '0;
      end else if (fe.ex_btb_update) begin
         if (fe.ex_btb_taken)
            btb_vld[wr_idx] <= 1'b1;
         else if (btb_tag[wr_idx] == wr_tag)
            btb_vld[wr_idx] <= 1'b0;
      end
   end

   // Payload arrays need no reset; the valid bits gate them
   always_ff @(posedge clk_core) begin
      if (!reset && fe.ex_btb_update && fe.ex_btb_taken) begin
         btb_tag[wr_idx] <= wr_tag;
         btb_tgt[wr_idx] <= fe.ex_btb_target;
      end
   end

   assign fe.fe0_valid       = valid_q;
   assign fe.fe0_specid      = specid_q;
   assign fe.fe0_read_addr   = pc_q;
   assign fe.fe0_ic_read_req = valid_q &
      (~fe.fe1_stall | fe.csr_kill | mispredict);

endmodule

// File: tb/tb_stage_fetch0.sv
// Directed bench for stage_fetch0 with an expectation queue
// drained by an independent negedge monitor.
module tb_stage_fetch0;

   logic clk = 1'b0;
   logic reset;

   stage_fetch0_if bus ();

   stage_fetch0 #(
      .RESET_PC   (32'h8000_0000),
      .BTB_ENTRIES(16)
   ) dut (
      .clk_core(clk),
      .reset   (reset),
      .fe      (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        v;
      logic        s;
      logic [29:0] a;
      logic        r;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (bus.fe0_valid !== e.v || bus.fe0_specid !== e.s ||
             bus.fe0_read_addr !== e.a ||
             bus.fe0_ic_read_req !== e.r)
            $display("FAIL %s: got v=%0b s=%0b a=%h req=%0b, want v=%0b s=%0b a=%h req=%0b",
               e.name, bus.fe0_valid, bus.fe0_specid,
               bus.fe0_read_addr, bus.fe0_ic_read_req,
               e.v, e.s, e.a, e.r);
         else
            passed++;
      end
   end

   // Push expectation for the current cycle, then advance one edge
   task automatic ex(input string n, input logic v,
                     input logic s, input logic [29:0] a,
                     input logic r);
      exp_t e;
      e.name = n; e.v = v; e.s = s; e.a = a; e.r = r;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.fe1_stall       = 1'b0;
      bus.ex_valid        = 1'b0;
      bus.ex_specid       = 1'b0;
      bus.ex_br_taken     = 1'b0;
      bus.ex_br_ntaken    = 1'b0;
      bus.ex_br_target    = '0;
      bus.ex_btb_update   = 1'b0;
      bus.ex_btb_pc       = '0;
      bus.ex_btb_target   = '0;
      bus.ex_btb_taken    = 1'b0;
      bus.csr_kill        = 1'b0;
      bus.csr_redirect_pc = '0;
   endtask

   task automatic btb(input logic [29:0] pc,
                      input logic [29:0] tgt, input logic tk);
      bus.ex_btb_update = 1'b1;
      bus.ex_btb_pc     = pc;
      bus.ex_btb_target = tgt;
      bus.ex_btb_taken  = tk;
   endtask

   task automatic csr(input logic [29:0] pc);
      bus.csr_kill        = 1'b1;
      bus.csr_redirect_pc = pc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      clr();
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
         ex("reset", 1'b0, 1'b0, 30'h2000_0000, 1'b0);
      reset = 1'b0;
      ex("release", 1'b0, 1'b0, 30'h2000_0000, 1'b0);
      for (int i = 0; i < 4; i++)
         ex("seq", 1'b1, 1'b0, 30'h2000_0000 + 30'(i), 1'b1);

      bus.fe1_stall = 1'b1;
      for (int i = 0; i < 4; i++)
         ex("stall", 1'b1, 1'b0, 30'h2000_0004, 1'b0);
      bus.fe1_stall = 1'b0;
      ex("stall_rel", 1'b1, 1'b0, 30'h2000_0004, 1'b1);
      ex("after_stall", 1'b1, 1'b0, 30'h2000_0005, 1'b1);

      bus.fe1_stall    = 1'b1;
      bus.ex_valid     = 1'b1;
      bus.ex_br_taken  = 1'b1;
      bus.ex_br_target = 30'h100;
      ex("mp_t_req", 1'b1, 1'b0, 30'h2000_0006, 1'b1);
      clr();
      ex("mp_taken", 1'b1, 1'b1, 30'h100, 1'b1);

      bus.ex_valid     = 1'b1;
      bus.ex_br_ntaken = 1'b1;
      bus.ex_br_target = 30'h40;
      ex("mp_nt_req", 1'b1, 1'b1, 30'h101, 1'b1);
      clr();
      ex("mp_ntaken", 1'b1, 1'b0, 30'h40, 1'b1);

      bus.fe1_stall    = 1'b1;
      bus.ex_valid     = 1'b1;
      bus.ex_br_ntaken = 1'b1;
      bus.ex_br_target = 30'h300;
      ex("no_mp_req", 1'b1, 1'b0, 30'h41, 1'b0);
      clr();
      ex("no_mp", 1'b1, 1'b0, 30'h41, 1'b1);

      btb(30'h10, 30'h80, 1'b1);
      ex("btb_wr", 1'b1, 1'b0, 30'h42, 1'b1);
      clr();
      csr(30'h0E);
      ex("csr_req", 1'b1, 1'b0, 30'h43, 1'b1);
      clr();
      ex("csr_0e", 1'b1, 1'b0, 30'h0E, 1'b1);
      ex("seq_0f", 1'b1, 1'b0, 30'h0F, 1'b1);
      ex("at_br", 1'b1, 1'b0, 30'h10, 1'b1);
      ex("btb_hit", 1'b1, 1'b1, 30'h80, 1'b1);

      btb(30'h20, 30'h0, 1'b0);
      ex("alias_inv", 1'b1, 1'b1, 30'h81, 1'b1);
      clr();
      csr(30'h10);
      ex("csr2_req", 1'b1, 1'b1, 30'h82, 1'b1);
      clr();
      ex("at_br2", 1'b1, 1'b1, 30'h10, 1'b1);
      ex("alias_kept", 1'b1, 1'b0, 30'h80, 1'b1);

      btb(30'h10, 30'h0, 1'b0);
      ex("inv", 1'b1, 1'b0, 30'h81, 1'b1);
      clr();
      csr(30'h10);
      ex("csr3_req", 1'b1, 1'b0, 30'h82, 1'b1);
      clr();
      ex("at_br3", 1'b1, 1'b0, 30'h10, 1'b1);
      ex("inv_fall", 1'b1, 1'b0, 30'h11, 1'b1);

      csr(30'h3F0);
      bus.ex_valid     = 1'b1;
      bus.ex_br_taken  = 1'b1;
      bus.ex_br_target = 30'h55;
      ex("prio_req", 1'b1, 1'b0, 30'h12, 1'b1);
      clr();
      ex("prio_csr", 1'b1, 1'b0, 30'h3F0, 1'b1);

      reset = 1'b1;
      csr(30'h3F0);
      bus.ex_valid     = 1'b1;
      bus.ex_br_taken  = 1'b1;
      bus.ex_br_target = 30'h55;
      ex("prio_rst_req", 1'b1, 1'b0, 30'h3F1, 1'b1);
      clr();
      reset = 1'b0;
      ex("prio_rst", 1'b0, 1'b0, 30'h2000_0000, 1'b0);

      btb(30'h5, 30'h5, 1'b1);
      csr(30'h3FFF_FFFE);
      ex("loop_wr", 1'b1, 1'b0, 30'h2000_0000, 1'b1);
      clr();
      ex("pre_wrap", 1'b1, 1'b0, 30'h3FFF_FFFE, 1'b1);
      ex("top", 1'b1, 1'b0, 30'h3FFF_FFFF, 1'b1);
      for (int i = 0; i < 5; i++)
         ex("wrap", 1'b1, 1'b0, 30'(i), 1'b1);
      ex("loop1", 1'b1, 1'b0, 30'h5, 1'b1);
      ex("loop2", 1'b1, 1'b1, 30'h5, 1'b1);
      ex("loop3", 1'b1, 1'b0, 30'h5, 1'b1);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/stage_fetch0.md
Name: stage_fetch0

Overview:
- First instruction-fetch stage. Owns the architectural fetch PC and drives the address and speculation ID into stage_fetch1 and the icache read port.
- Chooses the next PC from these sources: reset vector, CSR redirect (trap/xret), execute mispredict recovery, a direct-mapped BTB prediction, or sequential PC+4.
- Maintains the 1-bit speculation ID (specid) that downstream stages use to kill wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] are ignored.
- BTB_ENTRIES, 16, number of direct-mapped BTB entries; must be a power of 2 and at least 2.

Ports:
- clk_core  in  1  core clock
- reset  in  1  synchronous, active-high reset
- fe0_valid  out  1  fe0_read_addr holds a fetch request
- fe1_stall  in  1  fetch1 cannot accept a new request
- fe0_specid  out  1  specid of the current request
- fe0_read_addr  out  30  [31:2] fetch word address
- fe0_ic_read_req  out  1  icache array read enable
- ex_valid  in  1  execute holds a valid instruction
- ex_specid  in  1  specid of the resolving branch
- ex_br_taken  in  1  execute resolved a branch taken
- ex_br_ntaken  in  1  execute resolved a branch not-taken
- ex_br_target  in  30  [31:2] correct next PC for the resolving branch (target if taken, PC+4 if not)
- ex_btb_update  in  1  write the BTB this cycle
- ex_btb_pc  in  30  [31:2] branch PC
- ex_btb_target  in  30  [31:2] branch target
- ex_btb_taken  in  1  1 = allocate/overwrite entry, 0 = invalidate on tag match
- csr_kill  in  1  CSR redirect (trap, xret, fence.i)
- csr_redirect_pc  in  30  [31:2] CSR redirect target

Behaviour:
- Reset: fe0_valid=0, fe0_specid=0, fe0_read_addr=RESET_PC[31:2], all BTB valid bits=0. Reset takes priority over every other input, including mid-redirect and mid-BTB-update.
- The cycle after reset deasserts, fe0_valid=1. fe0_valid then stays 1; this block has no idle state.
- fe0_read_addr and fe0_specid are registered outputs.
- Mispredict: mispredict = ex_valid & ((fe0_specid ^ ex_specid) ? ex_br_ntaken : ex_br_taken). This is the same kill equation fetch1 uses.
- Next-state priority, evaluated every cycle:
  1. reset
  2. csr_kill: pc <= csr_redirect_pc; specid unchanged.
  3. mispredict: pc <= ex_br_target; specid <= ex_br_taken ? ~ex_specid : ex_specid.
  4. fe1_stall: hold pc and specid.
  5. BTB hit on pc: pc <= btb target; specid <= ~specid.
  6. Otherwise: pc <= pc + 1 (word increment), wrapping from 30'h3FFF_FFFF to 0.
- Redirects (items 2 and 3) take effect regardless of fe1_stall. The request presented during the redirect cycle is wrong-path; fetch1 discards it through its own kill logic.
- fe0_ic_read_req = fe0_valid & (~fe1_stall | csr_kill | mispredict). The array is read at the same edge fetch1 captures fe0_read_addr.
- BTB structure:
  - Index = pc[IDXW+1:2], where IDXW = log2(BTB_ENTRIES).
  - Each entry holds valid, tag = pc[31:IDXW+2], and target[31:2].
  - Lookup is combinational on the current fe0_read_addr; hit = valid & tag match.
  - A prediction is consumed only when fe0 advances, i.e. no stall and no redirect.
- BTB update (one write per cycle):
  - ex_btb_taken=1: write valid=1, tag, target at index(ex_btb_pc).
  - ex_btb_taken=0: clear valid only if the stored tag matches ex_btb_pc.
- An update and a lookup to the same index in the same cycle: the lookup sees the old contents; the write is visible the next cycle.
- csr_kill together with mispredict: csr_kill wins, and specid is not modified.
- Self-loop predicted branch (target == pc): the BTB hit repeats every cycle and specid toggles every cycle. This is legal.

Test Plan:
- Reset: assert reset 3 cycles with RESET_PC=32'h8000_0000, then release. fe0_valid=0 during reset and 1 one cycle after release. fe0_read_addr steps 30'h2000_0000, 30'h2000_0001, 30'h2000_0002 on successive cycles. specid=0.
- Stall: hold fe1_stall=1 for 4 cycles at addr 30'h2000_0004. Address and specid stay constant and fe0_ic_read_req=0. On release, the next cycle shows 30'h2000_0005.
- Mispredict taken: specid=0; ex_valid=1, ex_specid=0, ex_br_taken=1, ex_br_target=30'h0000_0100, asserted during a stall. Next cycle addr=30'h100, specid=1.
- Mispredict not-taken with differing specid: fe0_specid=1, ex_specid=0, ex_br_ntaken=1, target 30'h40. Next cycle addr=30'h40, specid=0. With equal specids and ex_br_ntaken=1, there is no redirect.
- BTB: update pc 30'h10 -> target 30'h80, taken=1. When fetch reaches 30'h10, the next address is 30'h80 and specid toggles. Then update pc 30'h10 with taken=0; the next visit falls through to 30'h11. An aliasing update with taken=0 (pc 30'h20 with 16 entries) leaves the entry intact.
- Priority: assert csr_kill (csr_redirect_pc=30'h3F0) and a mispredict (ex_br_target=30'h55) in the same cycle. Next addr=30'h3F0 and specid is unchanged. Asserting reset together with both gives RESET_PC.
